// File: rtl/restock_controller_pkg.sv
// restock_controller_pkg
// Shared definitions for the vending-machine restock controller:
//   - FSM state codes (also shown on state_o for the display)
//   - quantity keypad width and its one-hot key codes (KEY_Q1 is the top key)
//   - default counter width, capacity and slot count
package restock_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PICK_SLOT = 3'd1,
    ST_PICK_QTY  = 3'd2,
    ST_CHECK     = 3'd3,
    ST_COMMIT    = 3'd4,
    ST_ERR       = 3'd5
  } state_e;

  localparam int QTY_KEY_W = 7;

  localparam logic [QTY_KEY_W-1:0] KEY_Q1 = 7'b1000000;
  localparam logic [QTY_KEY_W-1:0] KEY_Q2 = 7'b0100000;
  localparam logic [QTY_KEY_W-1:0] KEY_Q3 = 7'b0010000;
  localparam logic [QTY_KEY_W-1:0] KEY_Q4 = 7'b0001000;
  localparam logic [QTY_KEY_W-1:0] KEY_Q5 = 7'b0000100;
  localparam logic [QTY_KEY_W-1:0] KEY_Q6 = 7'b0000010;
  localparam logic [QTY_KEY_W-1:0] KEY_Q7 = 7'b0000001;

  localparam int DEF_SLOTS = 4;
  localparam int DEF_CW    = 4;
  localparam int DEF_CAP   = 15;

endpackage

// File: rtl/restock_controller_if.sv
// restock_controller_if
// Bundles the operator pad, the sale handshake and the status/display
// outputs of the restock controller.
//   master : front end / sales controller side (drives pad + sale_req/slot)
//   slave  : restock_controller side (drives acks, stock and status)
// Optional: RESTOCK_SATURATE_EN adds the sat pulse.
interface restock_controller_if #(
  parameter int SLOTS = 4,
  parameter int CW    = 4
);
  // Sale slot index width; kept at least 1 bit so a single-slot build elaborates.
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic                  admin_en;
  logic [SLOTS-1:0]      slot_sel;
  logic [6:0]            qty_onehot;
  logic                  confirm;
  logic                  cancel;
  logic                  sale_req;
  logic [SW-1:0]         sale_slot;
  logic                  sale_ack;
  logic                  sale_empty;
  logic [SLOTS*CW-1:0]   stock_flat;
  logic                  busy;
  logic [2:0]            state_o;
  logic                  done;
  logic                  err;
`ifdef RESTOCK_SATURATE_EN
  logic                  sat;
`endif

  modport master (
    output admin_en, slot_sel, qty_onehot, confirm, cancel, sale_req, sale_slot,
    input  sale_ack, sale_empty, stock_flat, busy, state_o, done, err
`ifdef RESTOCK_SATURATE_EN
    , input sat
`endif
  );

  modport slave (
    input  admin_en, slot_sel, qty_onehot, confirm, cancel, sale_req, sale_slot,
    output sale_ack, sale_empty, stock_flat, busy, state_o, done, err
`ifdef RESTOCK_SATURATE_EN
    , output sat
`endif
  );

endinterface

// File: rtl/restock_controller_qty_key_decode.sv
// qty_key_decode
// Combinational decode of the 7-key one-hot quantity pad into a 3-bit
// quantity (1..7). Zero or multi-hot codes give valid_o=0 and qty_o=0.
// Also usable by the display path.
//   key_i   : one-hot key code (KEY_Q1 = MSB)
//   qty_o   : decoded quantity
//   valid_o : key_i was exactly one key
module qty_key_decode
  import restock_controller_pkg::*;
(
  input  logic [QTY_KEY_W-1:0] key_i,
  output logic [2:0]           qty_o,
  output logic                 valid_o
);

  always_comb begin
    qty_o   = 3'd0;
    valid_o = 1'b1;
    case (key_i)
      KEY_Q1:  qty_o = 3'd1;
      KEY_Q2:  qty_o = 3'd2;
      KEY_Q3:  qty_o = 3'd3;
      KEY_Q4:  qty_o = 3'd4;
      KEY_Q5:  qty_o = 3'd5;
      KEY_Q6:  qty_o = 3'd6;
      KEY_Q7:  qty_o = 3'd7;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/restock_controller.sv
// restock_controller
// Holds the per-slot stock counters and runs the operator restock flow
// (slot -> quantity -> confirm), sharing the single counter write path
// with sale decrements from the sales controller.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : restock_controller_if.slave (pad inputs, sale handshake,
//           stock_flat, busy, state_o, done, err[, sat])
// Optional: RESTOCK_SATURATE_EN -- overflowing restocks clamp to CAP and
//           pulse sat with done instead of going to ERR.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | serves sales; enters restock on admin_en
// PICK_SLOT | waiting for confirm with a one-hot slot_sel
// PICK_QTY  | waiting for confirm with a one-hot quantity key
// CHECK     | one cycle: stock+qty compared against CAP
// COMMIT    | one cycle: counter written, done pulsed next cycle
// ERR       | err high; leave on cancel or admin_en low
module restock_controller
  import restock_controller_pkg::*;
#(
  parameter int SLOTS      = DEF_SLOTS,
  parameter int CW         = DEF_CW,
  parameter int CAP        = DEF_CAP,
  parameter int INIT_STOCK = 0
)(
  input  logic clk,
  input  logic rst_n,
  restock_controller_if.slave bus
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW:0]      CAP_W  = (CW+1)'(CAP);
  localparam logic [CW-1:0]    INIT_C = CW'(INIT_STOCK);
  localparam logic [SLOTS-1:0] ONE_S  = SLOTS'(1);
`ifdef RESTOCK_SATURATE_EN
  localparam logic [CW-1:0]    CAP_C  = CW'(CAP);
`endif

  state_e state_q, state_d;

  logic [CW-1:0] stock_q [SLOTS];
  logic [SW-1:0] slot_idx_q;
  logic [2:0]    qty_q;
  logic          sale_ack_q;
  logic          sale_empty_q;
  logic          done_q;
`ifdef RESTOCK_SATURATE_EN
  logic          over_q;
  logic          sat_q;
`endif

  // ---------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------
  logic [2:0] key_qty;
  logic       key_valid;

  qty_key_decode u_qty_key_decode (
    .key_i   (bus.qty_onehot),
    .qty_o   (key_qty),
    .valid_o (key_valid)
  );

  logic          slot_onehot;
  logic [SW-1:0] slot_enc;

  always_comb begin
    slot_enc = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (bus.slot_sel[i]) slot_enc = SW'(i);
    end
    slot_onehot = (bus.slot_sel != '0) &&
                  ((bus.slot_sel & (bus.slot_sel - ONE_S)) == '0);
  end

  // ---------------------------------------------------------------
  // Sale path
  // ---------------------------------------------------------------
  logic          sale_slot_ok;
  logic [CW-1:0] sale_stock;
  logic          sale_go;
  logic          sale_dec;

  always_comb begin
    sale_slot_ok = (32'(bus.sale_slot) < SLOTS);
    sale_stock   = sale_slot_ok ? stock_q[bus.sale_slot] : '0;
    // The requester still sees sale_req high during the ack/empty cycle;
    // skipping that cycle keeps one request from being served twice.
    sale_go      = (state_q == ST_IDLE) && bus.sale_req &&
                   !sale_ack_q && !sale_empty_q;
    sale_dec     = sale_go && (sale_stock != '0);
  end

  // ---------------------------------------------------------------
  // Restock arithmetic (one bit wider so the overflow is visible)
  // ---------------------------------------------------------------
  logic [CW-1:0] sel_stock;
  logic [CW:0]   sum_w;
  logic          over_w;
  logic [CW-1:0] commit_val;

  always_comb begin
    sel_stock = stock_q[slot_idx_q];
    sum_w     = (CW+1)'(sel_stock) + (CW+1)'(qty_q);
    over_w    = (sum_w > CAP_W);
`ifdef RESTOCK_SATURATE_EN
    commit_val = over_q ? CAP_C : sum_w[CW-1:0];
`else
    commit_val = sum_w[CW-1:0];
`endif
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // A pending sale holds the controller in IDLE, ahead of admin_en.
        if (!bus.sale_req && bus.admin_en) state_d = ST_PICK_SLOT;
      end
      ST_PICK_SLOT: begin
        if (bus.cancel || !bus.admin_en) state_d = ST_IDLE;
        else if (bus.confirm)            state_d = slot_onehot ? ST_PICK_QTY : ST_ERR;
      end
      ST_PICK_QTY: begin
        if (bus.cancel || !bus.admin_en) state_d = ST_IDLE;
        else if (bus.confirm)            state_d = key_valid ? ST_CHECK : ST_ERR;
      end
      ST_CHECK: begin
`ifdef RESTOCK_SATURATE_EN
        state_d = ST_COMMIT;
`else
        state_d = over_w ? ST_ERR : ST_COMMIT;
`endif
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_ERR: begin
        if (bus.cancel || !bus.admin_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    bus.busy    = (state_q != ST_IDLE);
    bus.err     = (state_q == ST_ERR);
    bus.state_o = state_q;
  end

  // ---------------------------------------------------------------
  // Counters, latches and pulses
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) stock_q[i] <= INIT_C;
      slot_idx_q   <= '0;
      qty_q        <= '0;
      sale_ack_q   <= 1'b0;
      sale_empty_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef RESTOCK_SATURATE_EN
      over_q       <= 1'b0;
      sat_q        <= 1'b0;
`endif
    end else begin
      sale_ack_q   <= sale_dec;
      sale_empty_q <= sale_go && !sale_dec;
      done_q       <= (state_q == ST_COMMIT);
`ifdef RESTOCK_SATURATE_EN
      sat_q        <= (state_q == ST_COMMIT) && over_q;
      if (state_q == ST_CHECK) over_q <= over_w;
`endif
      if (state_q == ST_PICK_SLOT && state_d == ST_PICK_QTY) slot_idx_q <= slot_enc;
      if (state_q == ST_PICK_QTY  && state_d == ST_CHECK)    qty_q      <= key_qty;

      // Sales only happen in IDLE and commits only in COMMIT, so at most
      // one counter is written per cycle.
      if (sale_dec)                   stock_q[bus.sale_slot] <= sale_stock - CW'(1);
      else if (state_q == ST_COMMIT)  stock_q[slot_idx_q]    <= commit_val;
    end
  end

  always_comb begin
    bus.stock_flat = '0;
    for (int i = 0; i < SLOTS; i++) bus.stock_flat[i*CW +: CW] = stock_q[i];
  end

  assign bus.sale_ack   = sale_ack_q;
  assign bus.sale_empty = sale_empty_q;
  assign bus.done       = done_q;
`ifdef RESTOCK_SATURATE_EN
  assign bus.sat        = sat_q;
`endif

endmodule

// File: tb/tb_restock_controller.sv
module tb_restock_controller;
  import restock_controller_pkg::*;

  logic clk;
  logic rst_n;

  restock_controller_if #(.SLOTS(4), .CW(4)) bus ();

  restock_controller #(.SLOTS(4), .CW(4), .CAP(15), .INIT_STOCK(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic adm, input logic [3:0] ss, input logic [6:0] k,
                     input logic cf, input logic cn, input logic sr, input logic [1:0] sl);
    bus.admin_en   = adm;
    bus.slot_sel   = ss;
    bus.qty_onehot = k;
    bus.confirm    = cf;
    bus.cancel     = cn;
    bus.sale_req   = sr;
    bus.sale_slot  = sl;
  endtask

  typedef struct {
    logic        adm;
    logic [3:0]  ss;
    logic [6:0]  k;
    logic        cf, cn, sr;
    logic [1:0]  sl;
    logic [2:0]  st;
    logic        ack, emp, dn, er;
    logic [15:0] stock;
  } vec_t;

  function automatic vec_t mk(input logic adm, input logic [3:0] ss, input logic [6:0] k,
                              input logic cf, input logic cn, input logic sr, input logic [1:0] sl,
                              input logic [2:0] st, input logic ack, input logic emp,
                              input logic dn, input logic er, input logic [15:0] stock);
    vec_t v;
    v.adm = adm; v.ss = ss; v.k = k; v.cf = cf; v.cn = cn; v.sr = sr; v.sl = sl;
    v.st = st; v.ack = ack; v.emp = emp; v.dn = dn; v.er = er; v.stock = stock;
    return v;
  endfunction

  // Expected outputs of a full restock of one slot.
  task automatic restock_ok(input string nm, input logic [3:0] ss, input logic [6:0] k,
                            input logic [15:0] exp_stock);
    drv(1, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
    chk({nm, "_pick_slot"}, 32'(bus.state_o), 1);
    drv(1, ss, 7'b0, 1, 0, 0, 0); cyc();
    drv(1, 4'b0000, k, 1, 0, 0, 0); cyc();
    chk({nm, "_check"}, 32'(bus.state_o), 3);
    drv(1, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
    chk({nm, "_done_early"}, 32'(bus.done), 0);
    cyc();
    chk({nm, "_done"}, 32'(bus.done), 1);
    chk({nm, "_stock"}, 32'(bus.stock_flat), 32'(exp_stock));
    chk({nm, "_idle"}, 32'(bus.state_o), 0);
    drv(0, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
  endtask

  vec_t tbl [26];

  initial begin
    tbl[0]  = mk(1, 4'b0000, 7'b0,      0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 4'b0100, 7'b0,      1, 0, 0, 0,  2, 0, 0, 0, 0, 16'h0000);
    tbl[2]  = mk(1, 4'b0000, KEY_Q3,    1, 0, 0, 0,  3, 0, 0, 0, 0, 16'h0000);
    tbl[3]  = mk(1, 4'b0000, 7'b0,      0, 0, 0, 0,  4, 0, 0, 0, 0, 16'h0000);
    tbl[4]  = mk(0, 4'b0000, 7'b0,      0, 0, 0, 0,  0, 0, 0, 1, 0, 16'h0300);
    tbl[5]  = mk(0, 4'b0000, 7'b0,      0, 0, 1, 2,  0, 1, 0, 0, 0, 16'h0200);
    tbl[6]  = mk(0, 4'b0000, 7'b0,      0, 0, 0, 0,  0, 0, 0, 0, 0, 16'h0200);
    tbl[7]  = mk(0, 4'b0000, 7'b0,      0, 0, 1, 0,  0, 0, 1, 0, 0, 16'h0200);
    tbl[8]  = mk(0, 4'b0000, 7'b0,      0, 0, 0, 0,  0, 0, 0, 0, 0, 16'h0200);
    tbl[9]  = mk(1, 4'b0000, 7'b0,      0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0200);
    tbl[10] = mk(1, 4'b0001, 7'b0,      1, 1, 0, 0,  0, 0, 0, 0, 0, 16'h0200);
    tbl[11] = mk(1, 4'b0000, 7'b0,      0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0200);
    tbl[12] = mk(1, 4'b0010, 7'b0,      1, 0, 0, 0,  2, 0, 0, 0, 0, 16'h0200);
    tbl[13] = mk(0, 4'b0000, 7'b0,      0, 0, 0, 0,  0, 0, 0, 0, 0, 16'h0200);
    tbl[14] = mk(1, 4'b0000, 7'b0,      0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0200);
    tbl[15] = mk(1, 4'b0001, 7'b0,      1, 0, 0, 0,  2, 0, 0, 0, 0, 16'h0200);
    tbl[16] = mk(1, 4'b0000, 7'b0110000,1, 0, 0, 0,  5, 0, 0, 0, 1, 16'h0200);
    tbl[17] = mk(1, 4'b0000, 7'b0,      0, 0, 0, 0,  5, 0, 0, 0, 1, 16'h0200);
    tbl[18] = mk(1, 4'b0000, 7'b0,      0, 1, 0, 0,  0, 0, 0, 0, 0, 16'h0200);
    tbl[19] = mk(1, 4'b0000, 7'b0,      0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0200);
    tbl[20] = mk(1, 4'b0011, 7'b0,      1, 0, 0, 0,  5, 0, 0, 0, 1, 16'h0200);
    tbl[21] = mk(0, 4'b0000, 7'b0,      0, 0, 0, 0,  0, 0, 0, 0, 0, 16'h0200);
    tbl[22] = mk(1, 4'b0000, 7'b0,      0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0200);
    tbl[23] = mk(1, 4'b1000, 7'b0,      1, 0, 0, 0,  2, 0, 0, 0, 0, 16'h0200);
    tbl[24] = mk(1, 4'b0000, 7'b0,      1, 0, 0, 0,  5, 0, 0, 0, 1, 16'h0200);
    tbl[25] = mk(0, 4'b0000, 7'b0,      0, 0, 0, 0,  0, 0, 0, 0, 0, 16'h0200);

    // Reset
    drv(0, 4'b0000, 7'b0, 0, 0, 0, 0);
    rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_stock", 32'(bus.stock_flat), 0);
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_err",   32'(bus.err), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_ack",   32'(bus.sale_ack), 0);
    rst_n = 1'b1;
    cyc();

    // Table-driven cycle vectors
    for (int i = 0; i < 26; i++) begin
      drv(tbl[i].adm, tbl[i].ss, tbl[i].k, tbl[i].cf, tbl[i].cn, tbl[i].sr, tbl[i].sl);
      cyc();
      chk($sformatf("v%0d_state", i), 32'(bus.state_o),    32'(tbl[i].st));
      chk($sformatf("v%0d_busy",  i), 32'(bus.busy),       32'(tbl[i].st != 3'd0));
      chk($sformatf("v%0d_err",   i), 32'(bus.err),        32'(tbl[i].er));
      chk($sformatf("v%0d_done",  i), 32'(bus.done),       32'(tbl[i].dn));
      chk($sformatf("v%0d_ack",   i), 32'(bus.sale_ack),   32'(tbl[i].ack));
      chk($sformatf("v%0d_empty", i), 32'(bus.sale_empty), 32'(tbl[i].emp));
      chk($sformatf("v%0d_stock", i), 32'(bus.stock_flat), 32'(tbl[i].stock));
    end

    // Build slot 2 up to 13
    restock_ok("rs_q7", 4'b0100, KEY_Q7, 16'h0900);
    restock_ok("rs_q4", 4'b0100, KEY_Q4, 16'h0D00);

    // Overflow: 13 + 3 = 16 > 15
    drv(1, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
    drv(1, 4'b0100, 7'b0, 1, 0, 0, 0); cyc();
    drv(1, 4'b0000, KEY_Q3, 1, 0, 0, 0); cyc();
    chk("ovf_check", 32'(bus.state_o), 3);
    drv(1, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
`ifdef RESTOCK_SATURATE_EN
    chk("sat_commit", 32'(bus.state_o), 4);
    cyc();
    chk("sat_done",  32'(bus.done), 1);
    chk("sat_flag",  32'(bus.sat), 1);
    chk("sat_stock", 32'(bus.stock_flat), 32'h0F00);
    drv(0, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
    chk("sat_flag_off", 32'(bus.sat), 0);
`else
    chk("ovf_err_state", 32'(bus.state_o), 5);
    chk("ovf_err", 32'(bus.err), 1);
    cyc();
    chk("ovf_hold_state", 32'(bus.state_o), 5);
    chk("ovf_no_done", 32'(bus.done), 0);
    chk("ovf_stock", 32'(bus.stock_flat), 32'h0D00);
    drv(1, 4'b0000, 7'b0, 0, 1, 0, 0); cyc();
    chk("ovf_cancel_state", 32'(bus.state_o), 0);
    chk("ovf_cancel_err", 32'(bus.err), 0);
    drv(0, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
    // Exact fit: 13 + 2 = 15
    restock_ok("rs_cap", 4'b0100, KEY_Q2, 16'h0F00);
`endif

    // Sale held off during restock, served once back in IDLE
    drv(1, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
    drv(1, 4'b0010, 7'b0, 1, 0, 0, 0); cyc();
    chk("hold_pickqty", 32'(bus.state_o), 2);
    drv(1, 4'b0000, 7'b0, 0, 0, 1, 2); cyc();
    chk("hold_ack0", 32'(bus.sale_ack), 0);
    cyc();
    chk("hold_ack1", 32'(bus.sale_ack), 0);
    chk("hold_empty", 32'(bus.sale_empty), 0);
    chk("hold_stock", 32'(bus.stock_flat), 32'h0F00);
    drv(1, 4'b0000, KEY_Q1, 1, 0, 1, 2); cyc();
    chk("hold_check", 32'(bus.state_o), 3);
    drv(1, 4'b0000, 7'b0, 0, 0, 1, 2); cyc();
    chk("hold_commit_ack", 32'(bus.sale_ack), 0);
    cyc();
    chk("hold_done", 32'(bus.done), 1);
    chk("hold_done_ack", 32'(bus.sale_ack), 0);
    chk("hold_commit_stock", 32'(bus.stock_flat), 32'h0F10);
    cyc();
    chk("hold_served_ack", 32'(bus.sale_ack), 1);
    chk("hold_served_state", 32'(bus.state_o), 0);
    chk("hold_served_stock", 32'(bus.stock_flat), 32'h0E10);
    drv(0, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
    chk("hold_ack_off", 32'(bus.sale_ack), 0);

    // Reset in the middle of a restock
    drv(1, 4'b0000, 7'b0, 0, 0, 0, 0); cyc();
    drv(1, 4'b0001, 7'b0, 1, 0, 0, 0); cyc();
    chk("mid_pickqty", 32'(bus.state_o), 2);
    rst_n = 1'b0;
    drv(1, 4'b0000, KEY_Q5, 1, 0, 0, 0); cyc();
    chk("mid_rst_state", 32'(bus.state_o), 0);
    chk("mid_rst_stock", 32'(bus.stock_flat), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    drv(0, 4'b0000, 7'b0, 0, 0, 0, 0); cyc(); cyc();
    chk("mid_after_state", 32'(bus.state_o), 0);
    chk("mid_after_stock", 32'(bus.stock_flat), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/restock_controller.md
Name: restock_controller

Overview:
- Sequential controller for vending-machine slot inventory. It holds the per-slot stock counters and runs the operator restock flow: pick a slot, pick a quantity on the 7-key one-hot pad, then confirm.
- It also arbitrates the single stock-update path between operator restock and sale decrements from the sales controller.
- It sits between the keypad/switch front end and the sale/display logic.

Parameters:
- SLOTS, 4, number of product slots; one-hot slot select width.
- CW, 4, stock counter width per slot.
- CAP, 15, maximum stock per slot; must be ≤ 2^CW-1.
- INIT_STOCK, 0, value loaded into every counter at reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- admin_en  in  1  operator restock mode switch (level).
- slot_sel  in  SLOTS  one-hot slot choice.
- qty_onehot  in  7  quantity key; 7'b1000000=1, 7'b0100000=2, … 7'b0000001=7.
- confirm  in  1  single-cycle confirm pulse (already debounced).
- cancel  in  1  single-cycle abort pulse.
- sale_req  in  1  sale decrement request (level, held until ack or empty).
- sale_slot  in  $clog2(SLOTS)  binary slot index for sale.
- sale_ack  out  1  one-cycle pulse: sale decrement performed.
- sale_empty  out  1  one-cycle pulse: sale refused, stock was 0.
- stock_flat  out  SLOTS*CW  all counters; slot i at [i*CW +: CW].
- busy  out  1  high in any state other than IDLE.
- state_o  out  3  current FSM state code, for display.
- done  out  1  one-cycle pulse on a committed restock.
- err  out  1  high while in ERR.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; every counter=INIT_STOCK; sale_ack=sale_empty=done=err=busy=0; latched slot/qty cleared.
- State codes: IDLE=0, PICK_SLOT=1, PICK_QTY=2, CHECK=3, COMMIT=4, ERR=5.
- IDLE:
  - If sale_req=1, serve the sale this cycle; this takes priority over admin_en.
  - If the selected counter is >0, decrement it and pulse sale_ack next cycle.
  - If the selected counter is 0, pulse sale_empty next cycle and leave the counter unchanged.
  - sale_slot ≥ SLOTS is treated as empty.
  - Otherwise, if admin_en=1, go to PICK_SLOT.
- Sale requests outside IDLE are held off: no ack, no empty. The requester keeps sale_req high.
- PICK_SLOT:
  - On confirm, if slot_sel is exactly one-hot, latch its index and go to PICK_QTY.
  - Zero or multi-hot slot_sel goes to ERR.
- PICK_QTY:
  - On confirm, decode qty_onehot (1..7) and latch it.
  - A valid code goes to CHECK; zero or multi-hot goes to ERR.
- CHECK (1 cycle): compute stock+qty at CW+1 bits. Sum ≤ CAP goes to COMMIT; otherwise go to ERR.
- COMMIT (1 cycle): write stock+qty, pulse done, return to IDLE.
  - Confirm-to-counter-update latency is 2 cycles after the PICK_QTY confirm edge.
- ERR: err=1 and no counter change. Leave to IDLE on cancel or when admin_en drops.
- Abort: cancel=1, or admin_en=0, in PICK_SLOT or PICK_QTY returns to IDLE with no write.
  - CHECK and COMMIT always complete regardless of cancel or admin_en.
- confirm and cancel in the same cycle: cancel wins.
- Reset mid-restock: counters return to INIT_STOCK and the operation is discarded.
- Only one counter changes per cycle. Sale and restock writes are mutually exclusive by construction.

Optional Feature:
- RESTOCK_SATURATE_EN defined:
  - An overflow in CHECK does not go to ERR. COMMIT writes CAP instead of the sum.
  - done still pulses.
  - An extra output sat pulses together with done when clamping occurred.
- RESTOCK_SATURATE_EN undefined: overflow goes to ERR as above, and the sat port is absent.

Decomposition:
- Shared package/header restock_defs:
  - State codes.
  - QTY_KEY_W=7.
  - One-hot key constants KEY_Q1..KEY_Q7.
  - Default CAP/CW.
- One natural sub-module, qty_key_decode: combinational one-hot→3-bit quantity plus a valid flag. It is reusable by the display path.

Test Plan:
- Reset with INIT_STOCK=0 → all stock_flat=0, state_o=0, busy=0.
- Restock slot 2 (slot_sel=4'b0100), qty_onehot=7'b0010000 (3), two confirms → done pulse exactly 2 cycles after the second confirm; slot2=3; other slots unchanged.
- Slot2=13, restock qty 3 → ERR, err=1, slot2 stays 13; cancel → IDLE. With RESTOCK_SATURATE_EN: slot2=15 and sat=1.
- Sale: sale_req on slot 2 with stock 3 → sale_ack next cycle, slot2=2. Sale on slot 0 with stock 0 → sale_empty, no change.
- sale_req raised while in PICK_QTY → no ack. After commit returns to IDLE, the sale is served with the ack one cycle later.
- qty_onehot=7'b0110000 on confirm → ERR. confirm+cancel in the same cycle in PICK_SLOT → IDLE with no latch. admin_en dropped in PICK_QTY → IDLE with no write.
